// File: rtl/bram_tile_writer_if.sv
// Beat input handshake and BRAM write port of the tile writer.
// The writer connects through the slave modport; the beat source and BRAM side use master.
interface bram_tile_writer_if #(
  parameter int ADDRESS_WIDTH  = 13,
  parameter int DATA_IN_WIDTH  = 512,
  parameter int DATA_OUT_WIDTH = 32
);
  logic                      valid_i;
  logic                      ready_o;
  logic [DATA_IN_WIDTH-1:0]  data_i;
  logic [ADDRESS_WIDTH-1:0]  bram_addr_o;
  logic [DATA_OUT_WIDTH-1:0] bram_data_o;
  logic                      bram_en_o;
  logic                      bram_we_o;

  modport slave (
    input  valid_i, data_i,
    output ready_o, bram_addr_o, bram_data_o, bram_en_o, bram_we_o
  );

  modport master (
    output valid_i, data_i,
    input  ready_o, bram_addr_o, bram_data_o, bram_en_o, bram_we_o
  );
endinterface

// File: rtl/bram_tile_writer.sv
// Serialises wide result beats LSB-first into BRAM words written at consecutive
// addresses inside a circular window, with a one-beat skid buffer and start/done control.
module bram_tile_writer #(
  parameter int ADDRESS_WIDTH  = 13,
  parameter int DATA_IN_WIDTH  = 512,
  parameter int DATA_OUT_WIDTH = 32,
  parameter int BEAT_CNT_WIDTH = 16,
  localparam int WORDS         = DATA_IN_WIDTH / DATA_OUT_WIDTH,
  localparam int WPB_W         = $clog2(WORDS) + 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic [ADDRESS_WIDTH-1:0]  cfg_base_addr_i,
  input  logic [ADDRESS_WIDTH-1:0]  cfg_end_addr_i,
  input  logic [BEAT_CNT_WIDTH-1:0] cfg_num_beats_i,
  input  logic [WPB_W-1:0]          cfg_words_per_beat_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      wrap_o,
  bram_tile_writer_if.slave         bus
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t                    r_state;
  logic [ADDRESS_WIDTH-1:0]  r_base;
  logic [ADDRESS_WIDTH-1:0]  r_end;
  logic [ADDRESS_WIDTH-1:0]  r_ptr;
  logic [ADDRESS_WIDTH-1:0]  r_addr;
  logic [BEAT_CNT_WIDTH-1:0] r_num_beats;
  logic [BEAT_CNT_WIDTH-1:0] r_beats_acc;
  logic [WPB_W-1:0]          r_wpb;
  logic [WPB_W-1:0]          r_sh_rem;
  logic [DATA_IN_WIDTH-1:0]  r_sh_data;
  logic [DATA_IN_WIDTH-1:0]  r_sk_data;
  logic                      r_sk_valid;
  logic                      r_ptr_wrapped;
  logic                      r_ready;
  logic                      r_en;
  logic                      r_busy;
  logic                      r_done;
  logic                      r_wrap;
  logic [DATA_OUT_WIDTH-1:0] r_dout;

  logic [WPB_W-1:0]          w_wpb_cfg;
  logic                      w_accept;
  logic                      w_sh_busy;
  logic                      w_sh_last;
  logic                      w_sk_next;
  logic                      w_last_accept;
  logic                      w_emit;
  logic [BEAT_CNT_WIDTH-1:0] w_acc_next;
  logic [DATA_OUT_WIDTH-1:0] w_emit_data;

  assign w_wpb_cfg = ((cfg_words_per_beat_i == '0) || (cfg_words_per_beat_i > WPB_W'(WORDS)))
                     ? WPB_W'(WORDS) : cfg_words_per_beat_i;

  assign w_accept      = bus.valid_i & r_ready;
  assign w_sh_busy     = (r_sh_rem != '0);
  assign w_sh_last     = (r_sh_rem == WPB_W'(1));
  assign w_acc_next    = r_beats_acc + BEAT_CNT_WIDTH'(w_accept);
  // Skid holds a beat only while the shift register still has words after this cycle.
  assign w_sk_next     = w_sh_busy & ~w_sh_last & (r_sk_valid | w_accept);
  assign w_last_accept = w_accept & (w_acc_next == r_num_beats);
  // An idle shift register lets an accepted beat's word 0 go straight out.
  assign w_emit        = (r_state != IDLE) & (w_sh_busy | w_accept);
  assign w_emit_data   = w_sh_busy ? r_sh_data[DATA_OUT_WIDTH-1:0]
                                   : bus.data_i[DATA_OUT_WIDTH-1:0];

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state       <= IDLE;
      r_base        <= '0;
      r_end         <= '0;
      r_ptr         <= '0;
      r_addr        <= '0;
      r_num_beats   <= '0;
      r_beats_acc   <= '0;
      r_wpb         <= '0;
      r_sh_rem      <= '0;
      r_sh_data     <= '0;
      r_sk_data     <= '0;
      r_sk_valid    <= 1'b0;
      r_ptr_wrapped <= 1'b0;
      r_ready       <= 1'b0;
      r_en          <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_wrap        <= 1'b0;
      r_dout        <= '0;
    end else begin
      r_en   <= 1'b0;
      r_done <= 1'b0;

      if (w_emit) begin
        r_en   <= 1'b1;
        r_addr <= r_ptr;
        r_dout <= w_emit_data;
        r_wrap <= r_wrap | r_ptr_wrapped;
        if (r_ptr == r_end) begin
          r_ptr         <= r_base;
          r_ptr_wrapped <= 1'b1;
        end else begin
          r_ptr <= r_ptr + ADDRESS_WIDTH'(1);
        end
      end

      case (r_state)
        IDLE: begin
          if (start_i) begin
            if (cfg_num_beats_i != '0) begin
              r_base        <= cfg_base_addr_i;
              r_end         <= cfg_end_addr_i;
              r_num_beats   <= cfg_num_beats_i;
              r_wpb         <= w_wpb_cfg;
              r_ptr         <= cfg_base_addr_i;
              r_ptr_wrapped <= 1'b0;
              r_wrap        <= 1'b0;
              r_beats_acc   <= '0;
              r_sh_rem      <= '0;
              r_sk_valid    <= 1'b0;
              r_busy        <= 1'b1;
              r_ready       <= 1'b1;
              r_state       <= RUN;
            end else begin
              r_done <= 1'b1;
            end
          end
        end

        RUN, FLUSH: begin
          if (w_sh_busy) begin
            if (w_sh_last) begin
              // Next beat is loaded now so its word 0 follows without a bubble.
              if (r_sk_valid) begin
                r_sh_data  <= r_sk_data;
                r_sh_rem   <= r_wpb;
                r_sk_valid <= 1'b0;
              end else if (w_accept) begin
                r_sh_data <= bus.data_i;
                r_sh_rem  <= r_wpb;
              end else begin
                r_sh_rem <= '0;
              end
            end else begin
              r_sh_data <= r_sh_data >> DATA_OUT_WIDTH;
              r_sh_rem  <= r_sh_rem - WPB_W'(1);
              if (w_accept) begin
                r_sk_data  <= bus.data_i;
                r_sk_valid <= 1'b1;
              end
            end
          end else if (w_accept) begin
            r_sh_data <= bus.data_i >> DATA_OUT_WIDTH;
            r_sh_rem  <= r_wpb - WPB_W'(1);
          end

          r_beats_acc <= w_acc_next;
          r_ready     <= (r_state == RUN) & ~w_sk_next & (w_acc_next != r_num_beats);

          if ((r_state == RUN) && w_last_accept) begin
            r_state <= FLUSH;
          end else if ((r_state == FLUSH) && !w_sh_busy && !r_sk_valid) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.ready_o     = r_ready;
  assign bus.bram_addr_o = r_addr;
  assign bus.bram_data_o = r_dout;
  assign bus.bram_en_o   = r_en;
  assign bus.bram_we_o   = r_en;
  assign busy_o          = r_busy;
  assign done_o          = r_done;
  assign wrap_o          = r_wrap;

endmodule

// File: tb/tb_bram_tile_writer.sv
// Scoreboard bench for bram_tile_writer: the driver queues expected BRAM writes
// as beats are accepted, and a negedge monitor pops and compares every write.
module tb_bram_tile_writer;
  localparam int AW   = 13;
  localparam int DIW  = 512;
  localparam int DOW  = 32;
  localparam int BCW  = 16;
  localparam int WPBW = 5;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b0;
  logic            start_i = 1'b0;
  logic [AW-1:0]   cfg_base_addr_i = '0;
  logic [AW-1:0]   cfg_end_addr_i = '0;
  logic [BCW-1:0]  cfg_num_beats_i = '0;
  logic [WPBW-1:0] cfg_words_per_beat_i = '0;
  logic            busy_o;
  logic            done_o;
  logic            wrap_o;

  bram_tile_writer_if #(.ADDRESS_WIDTH(AW), .DATA_IN_WIDTH(DIW), .DATA_OUT_WIDTH(DOW)) bus ();

  bram_tile_writer #(
    .ADDRESS_WIDTH(AW), .DATA_IN_WIDTH(DIW), .DATA_OUT_WIDTH(DOW), .BEAT_CNT_WIDTH(BCW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .cfg_base_addr_i(cfg_base_addr_i), .cfg_end_addr_i(cfg_end_addr_i),
    .cfg_num_beats_i(cfg_num_beats_i), .cfg_words_per_beat_i(cfg_words_per_beat_i),
    .busy_o(busy_o), .done_o(done_o), .wrap_o(wrap_o),
    .bus(bus)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [AW-1:0]  addr;
    logic [DOW-1:0] data;
    logic           wrap;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int n_checks = 0;
  int n_fail   = 0;
  int n_writes = 0;
  int first_cyc = 0;
  int last_cyc  = 0;
  int cyc = 0;
  int dc;
  bit hit;
  bit done_seen;
  bit abort_send = 1'b0;

  logic [AW-1:0]   m_base, m_end, m_ptr;
  logic            m_wrap, m_after_wrap;
  logic [WPBW-1:0] m_wpb;

  always @(posedge clk_i) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DIW-1:0] make_beat(input int pat, input int b);
    logic [DIW-1:0] v;
    for (int k = 0; k < 16; k++)
      v[k*DOW +: DOW] = (pat == 0) ? (32'hA500_0000 + 32'(b << 8) + 32'(k)) : 32'(k + 16*b);
    return v;
  endfunction

  task automatic push_beat(input logic [DIW-1:0] beat);
    exp_t e;
    for (int k = 0; k < int'(m_wpb); k++) begin
      m_wrap = m_wrap | m_after_wrap;
      e.addr = m_ptr;
      e.data = beat[k*DOW +: DOW];
      e.wrap = m_wrap;
      sb.push_back(e);
      if (m_ptr == m_end) begin
        m_ptr = m_base;
        m_after_wrap = 1'b1;
      end else begin
        m_ptr = m_ptr + AW'(1);
      end
    end
  endtask

  task automatic do_start(input logic [AW-1:0] base, input logic [AW-1:0] lim,
                          input int beats, input int wpb_cfg, input int wpb_eff);
    @(negedge clk_i);
    cfg_base_addr_i      = base;
    cfg_end_addr_i       = lim;
    cfg_num_beats_i      = BCW'(beats);
    cfg_words_per_beat_i = WPBW'(wpb_cfg);
    start_i = 1'b1;
    if (beats != 0) begin
      m_base = base; m_end = lim; m_ptr = base;
      m_wrap = 1'b0; m_after_wrap = 1'b0; m_wpb = WPBW'(wpb_eff);
    end
    @(negedge clk_i);
    start_i = 1'b0;
    // Scramble config after start to show it was latched.
    cfg_base_addr_i = 13'h1ABC; cfg_end_addr_i = 13'h0003;
    cfg_num_beats_i = 16'd9;    cfg_words_per_beat_i = 5'd1;
  endtask

  task automatic send_beats(input int n, input int pat, input bit toggle);
    int b = 0;
    int t = 0;
    while (b < n) begin
      @(negedge clk_i);
      if (abort_send) return;
      if (t > 3000) begin
        n_checks++; n_fail++;
        $display("FAIL send_timeout: accepted=%0d required=%0d", b, n);
        bus.valid_i = 1'b0;
        return;
      end
      bus.valid_i = toggle ? (((t / 9) % 2) == 0) : 1'b1;
      bus.data_i  = bus.valid_i ? make_beat(pat, b) : {16{$urandom}};
      if (bus.valid_i && bus.ready_o) begin
        push_beat(bus.data_i);
        b++;
      end
      t++;
    end
    @(negedge clk_i);
    bus.valid_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int dcyc);
    dcyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_i);
      if (done_o) begin
        dcyc = cyc;
        break;
      end
    end
    chk("done_seen", 64'(dcyc >= 0), 64'd1);
  endtask

  always @(negedge clk_i) begin
    chk("we_eq_en", 64'(bus.bram_we_o), 64'(bus.bram_en_o));
    if (bus.bram_en_o) begin
      n_writes++;
      if (n_writes == 1) first_cyc = cyc;
      last_cyc = cyc;
      if (sb.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_write: addr=%0h data=%0h required=no write",
                 bus.bram_addr_o, bus.bram_data_o);
      end else begin
        mon_e = sb.pop_front();
        chk("wr_addr", 64'(bus.bram_addr_o), 64'(mon_e.addr));
        chk("wr_data", 64'(bus.bram_data_o), 64'(mon_e.data));
        chk("wr_wrap", 64'(wrap_o), 64'(mon_e.wrap));
      end
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_addr"},  64'(bus.bram_addr_o), 64'd0);
    chk({tag, "_data"},  64'(bus.bram_data_o), 64'd0);
    chk({tag, "_en"},    64'(bus.bram_en_o),   64'd0);
    chk({tag, "_ready"}, 64'(bus.ready_o),     64'd0);
    chk({tag, "_busy"},  64'(busy_o),          64'd0);
    chk({tag, "_done"},  64'(done_o),          64'd0);
    chk({tag, "_wrap"},  64'(wrap_o),          64'd0);
  endtask

  initial begin
    bus.valid_i = 1'b0;
    bus.data_i  = '0;
    repeat (3) @(negedge clk_i);
    chk_reset_vals("rst");
    rst_i = 1'b1;

    // Two full beats back to back: contiguous writes, done one cycle later.
    n_writes = 0;
    do_start(13'h100, 13'h1FFF, 2, 0, 16);
    send_beats(2, 0, 1'b0);
    wait_done(200, dc);
    chk("t1_writes", 64'(n_writes), 64'd32);
    chk("t1_contig", 64'(last_cyc - first_cyc), 64'd31);
    chk("t1_done_lat", 64'(dc - last_cyc), 64'd1);
    chk("t1_busy_at_done", 64'(busy_o), 64'd0);
    chk("t1_wrap", 64'(wrap_o), 64'd0);
    chk("t1_sb_empty", 64'(sb.size()), 64'd0);

    // wpb=4 with an ignored start pulse mid-run.
    n_writes = 0;
    do_start(13'h300, 13'h1FFF, 3, 4, 4);
    fork
      send_beats(3, 1, 1'b0);
      begin
        repeat (4) @(negedge clk_i);
        cfg_base_addr_i = 13'h050; cfg_num_beats_i = 16'd7;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
      end
    join
    wait_done(200, dc);
    chk("t2_writes", 64'(n_writes), 64'd12);
    chk("t2_sb_empty", 64'(sb.size()), 64'd0);

    // valid toggling every 9 cycles.
    n_writes = 0;
    do_start(13'h800, 13'h1FFF, 3, 16, 16);
    send_beats(3, 0, 1'b1);
    wait_done(400, dc);
    chk("t3_writes", 64'(n_writes), 64'd48);
    chk("t3_sb_empty", 64'(sb.size()), 64'd0);

    // Small window forces a wrap on the 5th write.
    n_writes = 0;
    do_start(13'h010, 13'h013, 1, 6, 6);
    send_beats(1, 1, 1'b0);
    wait_done(100, dc);
    chk("t4_writes", 64'(n_writes), 64'd6);
    repeat (3) @(negedge clk_i);
    chk("t4_wrap_held", 64'(wrap_o), 64'd1);

    // Start clears wrap; wpb above WORDS acts as WORDS.
    n_writes = 0;
    do_start(13'h200, 13'h20F, 1, 20, 16);
    chk("t5_wrap_cleared", 64'(wrap_o), 64'd0);
    send_beats(1, 0, 1'b0);
    wait_done(100, dc);
    chk("t5_writes", 64'(n_writes), 64'd16);
    chk("t5_wrap", 64'(wrap_o), 64'd0);

    // Zero-beat run.
    n_writes = 0;
    do_start(13'h000, 13'h1FFF, 0, 4, 4);
    chk("t6_done", 64'(done_o), 64'd1);
    chk("t6_busy", 64'(busy_o), 64'd0);
    @(negedge clk_i);
    chk("t6_done_pulse", 64'(done_o), 64'd0);
    repeat (10) @(negedge clk_i);
    chk("t6_writes", 64'(n_writes), 64'd0);

    // Reset after 5 words of a 2-beat run.
    n_writes = 0;
    abort_send = 1'b0;
    hit = 1'b0;
    do_start(13'h400, 13'h1FFF, 2, 16, 16);
    fork
      send_beats(2, 0, 1'b0);
      begin
        for (int i = 0; i < 100; i++) begin
          @(negedge clk_i);
          #1;
          if (n_writes == 5) begin
            rst_i = 1'b0;
            abort_send = 1'b1;
            bus.valid_i = 1'b0;
            hit = 1'b1;
            break;
          end
        end
      end
    join
    chk("t7_reset_hit", 64'(hit), 64'd1);
    @(negedge clk_i);
    chk_reset_vals("t7_rst");
    rst_i = 1'b1;
    sb.delete();
    done_seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_i);
      if (done_o) done_seen = 1'b1;
    end
    chk("t7_no_done", 64'(done_seen), 64'd0);
    chk("t7_writes_frozen", 64'(n_writes), 64'd5);

    n_writes = 0;
    abort_send = 1'b0;
    do_start(13'h400, 13'h1FFF, 1, 3, 3);
    send_beats(1, 1, 1'b0);
    wait_done(100, dc);
    chk("t7_rerun_writes", 64'(n_writes), 64'd3);
    chk("t7_rerun_sb_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/bram_tile_writer.md
Name: bram_tile_writer

Overview:
- Parametrised successor to the single-channel result writer.
- Accepts wide result beats from the GAN compute array over a valid/ready handshake and serialises each beat LSB-first into DATA_OUT_WIDTH words.
- Writes those words to a result BRAM at consecutive addresses inside a configurable circular window.
- Adds a per-run programmable beat count and words-per-beat, a one-beat skid buffer for bubble-free back-to-back beats, start/done control, and address wrap reporting.

Parameters:
- ADDRESS_WIDTH, 13, BRAM address width.
- DATA_IN_WIDTH, 512, input beat width; must be an integer multiple of DATA_OUT_WIDTH.
- DATA_OUT_WIDTH, 32, BRAM word width.
- BEAT_CNT_WIDTH, 16, width of the beat-count config field.
- WORDS, DATA_IN_WIDTH/DATA_OUT_WIDTH (local, 16 at defaults), words per full beat.

Ports:
- clk_i, input, 1, clock; all logic on rising edge.
- rst_i, input, 1, reset; synchronous, active-low.
- start_i, input, 1, 1-cycle pulse to begin a run; ignored while busy_o=1.
- cfg_base_addr_i, input, ADDRESS_WIDTH, first write address and wrap target; latched on start.
- cfg_end_addr_i, input, ADDRESS_WIDTH, last address of the window (inclusive); latched on start.
- cfg_num_beats_i, input, BEAT_CNT_WIDTH, number of beats in the run; latched on start.
- cfg_words_per_beat_i, input, $clog2(WORDS)+1, low-order words written per beat, range 1..WORDS; 0 or any value >WORDS is treated as WORDS; latched on start.
- valid_i, input, 1, data_i is valid.
- ready_o, output, 1, writer accepts a beat this cycle.
- data_i, input, DATA_IN_WIDTH, result beat.
- bram_addr_o, output, ADDRESS_WIDTH, write address.
- bram_data_o, output, DATA_OUT_WIDTH, write data.
- bram_en_o, output, 1, BRAM enable.
- bram_we_o, output, 1, BRAM write enable; always equals bram_en_o.
- busy_o, output, 1, run in progress.
- done_o, output, 1, 1-cycle pulse at end of run.
- wrap_o, output, 1, sticky; set when the address wraps during the run, cleared on start.

Behaviour:
- Reset (rst_i=0 at a clock edge) forces:
  - state IDLE; skid and shift buffers empty.
  - bram_addr_o = 0, bram_data_o = 0; bram_en_o, bram_we_o, ready_o, busy_o, done_o, wrap_o all 0.
  - Reset asserted mid-run aborts the run: no done_o pulse, and no write occurs on the reset cycle.
- FSM states: IDLE, RUN, FLUSH.
  - IDLE->RUN: start_i=1 and cfg_num_beats_i != 0. Latch config, load the address pointer with base, clear wrap_o, set busy_o=1.
  - IDLE with start_i=1 and cfg_num_beats_i=0: done_o pulses on the next cycle; busy_o stays 0.
  - RUN->FLUSH: last beat accepted.
  - FLUSH->IDLE: last word of the last beat written. done_o=1 and busy_o=0 on the following cycle.
- Handshake:
  - A beat transfers when valid_i and ready_o are both 1.
  - ready_o = (state==RUN) and skid buffer empty and beats_accepted < num_beats.
  - ready_o is registered; it has no combinational path from valid_i.
  - data_i is ignored whenever ready_o=0.
- Serialisation:
  - An accepted beat goes to the shift register if it is idle, otherwise to the skid buffer.
  - First word write occurs the cycle after acceptance (latency 1).
  - Word k = data_i[k*DATA_OUT_WIDTH +: DATA_OUT_WIDTH], for k = 0..wpb-1, one word per cycle.
  - Words k >= wpb are discarded.
  - When the current beat's last word is written, a beat in the skid buffer starts on the next cycle with no bubble. The skid buffer frees, so ready_o returns to 1 the cycle after that.
  - Sustained throughput is therefore one beat per wpb cycles.
- Address:
  - First write goes to base; the pointer increments after every write.
  - After writing at cfg_end_addr_i, the next write goes to base and wrap_o is set.
  - If end < base, the window wraps modulo 2^ADDRESS_WIDTH: the pointer rolls over from all-ones to 0 and still wraps at end.
- bram_en_o/bram_we_o are high only in cycles that carry a valid word.
- Total writes per run = num_beats * wpb.
- start_i while busy_o=1 is ignored; latched config does not change.

Test Plan:
- base=0x100, end=0x1FFF, beats=2, wpb=0 (=16), valid_i held 1 -> 32 writes at 0x100..0x11F, data equals beat words LSB-first, no idle write cycles between beats, done_o 1 cycle after last write, wrap_o=0.
- wpb=4, beats=3, data_i word k = k + 16*beat -> writes 0,1,2,3,16,17,18,19,32,33,34,35 at base..base+11; upper words never appear on bram_data_o.
- valid_i toggling 1/0 every 9 cycles with wpb=16 -> write count 16*beats, bram_en_o low only while the shift register is empty, no beat dropped or duplicated.
- base=0x10, end=0x13, beats=1, wpb=6 -> addresses 0x10,0x11,0x12,0x13,0x10,0x11; wrap_o=1 after the 5th write and held until the next start.
- rst_i=0 for 1 cycle after 5 words of a 2-beat run -> following cycle all outputs at reset values, no done_o; a new start runs cleanly from base.
- start_i with beats=0 -> done_o pulse, zero writes; start_i pulsed mid-run -> ignored, total writes unchanged.
